// File: rtl/instr_fetch_queue.sv
`timescale 1ns/1ps
// instr_fetch_queue
//
// Decoupled instruction fetch unit. It issues sequential fetch requests to an
// in-order, variable-latency instruction memory, buffers returned words in a
// DEPTH-entry queue and presents the queue head to decode. A redirect (taken
// branch or jump) flushes the queue, marks in-flight responses as stale, and
// restarts fetch at the computed target.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer never makes valid depend on ready. Head data is held
// stable while instr_valid && !instr_ready. Memory responses carry no ready:
// each asserted imem_rsp_valid cycle delivers exactly one word.
//
// Ports:
//   clk             clock, rising edge
//   start_up        asynchronous active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts request
//   imem_req_addr   fetch address (current fetch PC)
//   imem_rsp_valid  in-order response valid
//   imem_rsp_data   returned instruction word
//   instr_valid     queue head valid to decode
//   instr_ready     decode accepts head
//   instruction     queue head instruction
//   instr_pc        PC of queue head
//   redirect_valid  taken branch or jump this cycle
//   redirect_kind   0 = branch, 1 = jump
//   redirect_pc     PC of the branch/jump instruction
//   redirect_imm    jump target field; branch uses [15:0]
//   pc_q            current fetch PC register

module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h00400020,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        start_up,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic        redirect_kind,
    input  logic [31:0] redirect_pc,
    input  logic [25:0] redirect_imm,
    output logic [31:0] pc_q
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic        req_fire;
    logic        rsp_fire;
    logic        push;
    logic        pop;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;

    always_comb begin
        pc_plus4        = redirect_pc + 32'd4;
        branch_target   = pc_plus4 + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
        jump_target     = {pc_plus4[31:28], redirect_imm, 2'b00};
        redirect_target = redirect_kind ? jump_target : branch_target;
    end

    // Credit rule: a request is only issued if the queue already has a free
    // slot reserved for it, counting every word still in flight. This is what
    // keeps the queue from ever overflowing without a response-side stall.
    assign imem_req_valid = !start_up && !redirect_valid &&
                            (int'(outstanding) < MAX_OUTSTANDING) &&
                            ((int'(outstanding) + int'(count)) < DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign pc_q           = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    // Stale words (drop_cnt) and any word landing in a redirect cycle are discarded.
    assign push     = rsp_fire && (drop_cnt == '0) && !redirect_valid;
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (count != '0);
    assign instruction = q_instr[head];
    assign instr_pc    = q_pc[head];

    always_ff @(posedge clk or posedge start_up) begin
        if (start_up) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            // req_fire is never set in a redirect cycle, so this covers both paths.
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt <= outstanding - OW'(rsp_fire);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - 1'b1;
                    end else begin
                        rsp_pc <= rsp_pc + 32'd4;
                    end
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_rsp_data;
            q_pc[tail]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
`timescale 1ns/1ps
module tb_instr_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h00400020;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        start_up;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic        redirect_kind;
  logic [31:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic [31:0] pc_q;

  instr_fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .start_up(start_up),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind), .redirect_pc(redirect_pc),
    .redirect_imm(redirect_imm), .pc_q(pc_q)
  );

  // Second instance for the address-wrap and mid-flight reset checks.
  logic        w_start;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_instr_valid;
  logic [31:0] w_instruction;
  logic [31:0] w_instr_pc;
  logic [31:0] w_pc_q;

  instr_fetch_queue #(.RESET_PC(32'hFFFFFFFC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut_w (
    .clk(clk), .start_up(w_start),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instruction(w_instruction), .instr_pc(w_instr_pc),
    .redirect_valid(1'b0), .redirect_kind(1'b0), .redirect_pc(32'd0),
    .redirect_imm(26'd0), .pc_q(w_pc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    int          ready_cyc;
  } mem_req_t;
  mem_req_t mem_q[$];
  bit mem_rand, mem_hold, spurious_en;

  logic [31:0] m_fetch, m_rsp;
  int          m_out, m_drop;
  logic [31:0] exp_q[$];    // expected PCs in the instruction queue
  logic [31:0] exp_w[$];    // expected words, parallel to exp_q

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] calc_target(input logic kind, input logic [31:0] pc,
                                              input logic [25:0] imm);
    logic [31:0] nxt;
    int          off;
    nxt = pc + 32'd4;
    if (kind) return (nxt & 32'hF000_0000) | ({6'd0, imm} << 2);
    off = int'($signed(imm[15:0]));
    return nxt + 32'(off * 4);
  endfunction

  function automatic logic exp_req_valid();
    return !start_up && !redirect_valid && (m_out < MAXO) && ((m_out + exp_q.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_fetch = RST_PC;
    m_rsp   = RST_PC;
    m_out   = 0;
    m_drop  = 0;
    exp_q.delete();
    exp_w.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // drive: memory response for this cycle, then compare DUT against the model.
  task automatic drive();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if (!mem_hold && mem_q.size() != 0 && mem_q[0].ready_cyc <= cyc &&
        (!mem_rand || $urandom_range(0, 2) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else if (spurious_en && mem_q.size() == 0 && $urandom_range(0, 15) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom();
    end
    #1;
    if (start_up) begin
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_pc_q", pc_q, RST_PC);
    end else begin
      chk("req_valid", imem_req_valid, exp_req_valid());
      chk("req_addr", imem_req_addr, m_fetch);
      chk("pc_q", pc_q, m_fetch);
      chk("instr_valid", instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("instr_pc", instr_pc, exp_q[0]);
        chk("instruction", instruction, exp_w[0]);
      end
    end
  endtask

  // tick: clock edge, then advance the memory and the model by the rules.
  task automatic tick();
    bit req_f, rsp_f, pop_f;
    mem_req_t r;
    logic [31:0] t;
    @(posedge clk);
    #1;
    if (imem_rsp_valid && mem_q.size() != 0) void'(mem_q.pop_front());
    if (start_up) begin
      model_reset();
    end else begin
      req_f = exp_req_valid() && imem_req_ready;
      rsp_f = imem_rsp_valid && (m_out > 0);
      pop_f = (exp_q.size() != 0) && instr_ready;
      if (req_f) begin
        r.addr = m_fetch;
        r.ready_cyc = cyc + 1;
        mem_q.push_back(r);
      end
      if (redirect_valid) begin
        t = calc_target(redirect_kind, redirect_pc, redirect_imm);
        exp_q.delete();
        exp_w.delete();
        m_fetch = t;
        m_rsp   = t;
        if (rsp_f) m_out--;
        m_drop = m_out;
      end else begin
        if (pop_f) begin
          void'(exp_q.pop_front());
          void'(exp_w.pop_front());
        end
        if (rsp_f) begin
          if (m_drop > 0) m_drop--;
          else begin
            exp_q.push_back(m_rsp);
            exp_w.push_back(imem_rsp_data);
            m_rsp = m_rsp + 32'd4;
          end
          m_out--;
        end
        if (req_f) begin
          m_fetch = m_fetch + 32'd4;
          m_out++;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic do_reset(input int n);
    start_up = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) step();
    start_up = 1'b0;
    mem_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int rst_left;
    start_up = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_kind = 1'b0; redirect_pc = 32'd0; redirect_imm = 26'd0;
    w_start = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'd0;
    mem_rand = 0; mem_hold = 0; spurious_en = 0;
    model_reset();

    // reset values and first-fetch latency
    repeat (2) begin
      drive();
      chk("lit_rst_pc_q", pc_q, 32'h00400020);
      chk("lit_rst_instr_valid", instr_valid, 1'b0);
      tick();
    end
    start_up = 1'b0;
    mem_q.delete();
    drive();
    chk("lit_first_req_valid", imem_req_valid, 1'b1);
    chk("lit_first_req_addr", imem_req_addr, 32'h00400020);
    tick();
    drive();
    chk("lit_latency_not_yet", instr_valid, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive();
      chk("lit_stream_valid", instr_valid, 1'b1);
      chk("lit_stream_pc", instr_pc, 32'h00400020 + 32'(4 * i));
      tick();
    end

    // backpressure: fill, stall requests, then drain in order
    do_reset(2);
    instr_ready = 1'b0;
    repeat (10) step();
    drive();
    chk("lit_bp_req_stalled", imem_req_valid, 1'b0);
    chk("lit_bp_head_pc", instr_pc, 32'h00400020);
    chk("lit_bp_model_full", 32'(exp_q.size()), 32'd4);
    tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive();
      chk("lit_bp_drain_pc", instr_pc, 32'h00400020 + 32'(4 * i));
      tick();
    end
    repeat (8) step();

    // branch with two requests outstanding
    do_reset(2);
    mem_hold = 1;
    step();
    step();
    redirect_valid = 1'b1; redirect_kind = 1'b0;
    redirect_pc = 32'h00400024; redirect_imm = 26'h000FFFF;
    drive();
    chk("lit_br_outstanding", 32'(m_out), 32'd2);
    tick();
    redirect_valid = 1'b0;
    mem_hold = 0;
    drive();
    chk("lit_br_next_addr", imem_req_addr, 32'h00400024);
    chk("lit_br_drop", 32'(m_drop), 32'd2);
    tick();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      drive();
      if (instr_valid) begin
        seen = 1;
        chk("lit_br_first_pc", instr_pc, 32'h00400024);
        chk("lit_br_first_word", instruction, mem_word(32'h00400024));
      end
      tick();
    end
    if (!seen) chk("lit_br_valid_timeout", instr_valid, 1'b1);

    // jump
    redirect_valid = 1'b1; redirect_kind = 1'b1;
    redirect_pc = 32'h00400030; redirect_imm = 26'h0100010;
    step();
    redirect_valid = 1'b0;
    drive();
    chk("lit_jmp_pc_q", pc_q, 32'h00400040);
    chk("lit_jmp_req_addr", imem_req_addr, 32'h00400040);
    chk("lit_jmp_queue_empty", instr_valid, 1'b0);
    tick();
    repeat (10) step();

    // randomized traffic with redirects, resets and spurious responses
    mem_rand = 1; spurious_en = 1; rst_left = 0;
    for (int n = 0; n < 4000; n++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_kind  = 1'($urandom_range(0, 1));
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 : $urandom();
      redirect_imm   = 26'($urandom());
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = 2;
      start_up = (rst_left != 0);
      step();
      if (rst_left != 0) begin
        rst_left--;
        if (rst_left == 0) begin
          start_up = 1'b0;
          mem_q.delete();
        end
      end
    end
    redirect_valid = 1'b0;
    start_up = 1'b1;

    // wrap-around fetch and mid-flight reset on the second instance
    @(negedge clk); #1;
    chk("lit_w_rst_pc", w_pc_q, 32'hFFFFFFFC);
    chk("lit_w_rst_req", w_req_valid, 1'b0);
    w_start = 1'b0; #1;
    chk("lit_w_first_valid", w_req_valid, 1'b1);
    chk("lit_w_first_addr", w_req_addr, 32'hFFFFFFFC);
    @(negedge clk); #1;
    chk("lit_w_wrap_valid", w_req_valid, 1'b1);
    chk("lit_w_wrap_addr", w_req_addr, 32'h00000000);
    @(negedge clk); #1;
    chk("lit_w_credit_stop", w_req_valid, 1'b0);
    chk("lit_w_pc_after", w_pc_q, 32'h00000004);
    w_start = 1'b1; #1;
    chk("lit_w_midrst_pc", w_pc_q, 32'hFFFFFFFC);
    chk("lit_w_midrst_req", w_req_valid, 1'b0);
    chk("lit_w_midrst_iv", w_instr_valid, 1'b0);
    w_rsp_valid = 1'b1; w_rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk); #1;
    w_start = 1'b0;
    @(negedge clk); #1;
    w_rsp_valid = 1'b0;
    chk("lit_w_late_ignored", w_instr_valid, 1'b0);
    chk("lit_w_restart_addr", w_req_addr, 32'h00000000);
    @(negedge clk); #1;
    chk("lit_w_still_empty", w_instr_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
